// File: rtl/execute_pkg.sv
// Shared types for the execute stage: ALU/branch/muldiv opcodes, forward selects, FSM states.
package execute_pkg;

  typedef enum logic [3:0] {
    AluAdd   = 4'd0,
    AluSub   = 4'd1,
    AluAnd   = 4'd2,
    AluOr    = 4'd3,
    AluXor   = 4'd4,
    AluSlt   = 4'd5,
    AluSltu  = 4'd6,
    AluSll   = 4'd7,
    AluSrl   = 4'd8,
    AluSra   = 4'd9,
    AluPassB = 4'd10
  } alu_op_e;

  typedef enum logic [2:0] {
    BrEq  = 3'b000,
    BrNe  = 3'b001,
    BrLt  = 3'b100,
    BrGe  = 3'b101,
    BrLtu = 3'b110,
    BrGeu = 3'b111
  } branch_cond_e;

  typedef enum logic [2:0] {
    MdMul    = 3'b000,
    MdMulh   = 3'b001,
    MdMulhsu = 3'b010,
    MdMulhu  = 3'b011,
    MdDiv    = 3'b100,
    MdDivu   = 3'b101,
    MdRem    = 3'b110,
    MdRemu   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    FwdReg = 2'b00,
    FwdWb  = 2'b01,
    FwdMem = 2'b10
  } fwd_sel_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2
  } muldiv_state_e;

endpackage

// File: rtl/execute_stage_if.sv
// E-stage inputs and M-register / redirect outputs of the execute stage.
// master: decode/hazard side driving E; slave: the execute stage itself.
interface execute_stage_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  FlushE;
  logic                  RegWriteE, MemWriteE, JumpE, BranchE, JalrE, ALUSrcE, MulDivE;
  logic [1:0]            ResultsSrcE;
  logic [3:0]            ALUControlE;
  logic [2:0]            BranchCondE;
  logic [2:0]            MulDivOpE;
  logic [1:0]            ForwardAE, ForwardBE;
  logic [DATA_WIDTH-1:0] RD1E, RD2E, PCE, ImmExtE, PCPlus4E;
  logic [DATA_WIDTH-1:0] ResultW, ALUResultFwdM;
  logic [4:0]            RdE;

  logic                  RegWriteM, MemWriteM;
  logic [1:0]            ResultsSrcM;
  logic [DATA_WIDTH-1:0] ALUResultM, WriteDataM, PCPlus4M;
  logic [4:0]            RdM;
  logic [DATA_WIDTH-1:0] PCTargetE;
  logic                  PCSrcE;
  logic                  StallE;

  modport master (
    output FlushE, RegWriteE, MemWriteE, JumpE, BranchE, JalrE, ALUSrcE, MulDivE,
    output ResultsSrcE, ALUControlE, BranchCondE, MulDivOpE, ForwardAE, ForwardBE,
    output RD1E, RD2E, PCE, ImmExtE, PCPlus4E, ResultW, ALUResultFwdM, RdE,
    input  RegWriteM, MemWriteM, ResultsSrcM, ALUResultM, WriteDataM, PCPlus4M, RdM,
    input  PCTargetE, PCSrcE, StallE
  );

  modport slave (
    input  FlushE, RegWriteE, MemWriteE, JumpE, BranchE, JalrE, ALUSrcE, MulDivE,
    input  ResultsSrcE, ALUControlE, BranchCondE, MulDivOpE, ForwardAE, ForwardBE,
    input  RD1E, RD2E, PCE, ImmExtE, PCPlus4E, ResultW, ALUResultFwdM, RdE,
    output RegWriteM, MemWriteM, ResultsSrcM, ALUResultM, WriteDataM, PCPlus4M, RdM,
    output PCTargetE, PCSrcE, StallE
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative M-extension unit: one product/quotient bit per BUSY cycle.
// Multiply is shift-add on magnitudes, divide is restoring; signs fixed up at the end.
// Only built when EXECUTE_MULDIV_EN is defined.
`ifdef EXECUTE_MULDIV_EN
module muldiv_unit
  import execute_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  flush_i,
  input  logic [2:0]            op_i,
  input  logic [DATA_WIDTH-1:0] op_a_i,
  input  logic [DATA_WIDTH-1:0] op_b_i,
  output logic                  stall_o,
  output logic [DATA_WIDTH-1:0] result_o
);
  localparam int unsigned CntW = $clog2(DATA_WIDTH);

  muldiv_state_e         state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  muldiv_op_e            op_q;
  // hi: product high half / remainder; lo: multiplier->product low / dividend->quotient
  logic [DATA_WIDTH-1:0] hi_q, lo_q, den_q, dividend_q;
  logic [DATA_WIDTH-1:0] hi_d, lo_d;
  logic                  neg_q, neg_rem_q, zero_q;

  logic                  load, step, is_div, a_signed, b_signed, sa, sb;
  logic [DATA_WIDTH-1:0] mag_a, mag_b;

  assign load     = (state_q == StIdle) && start_i && !flush_i;
  assign step     = (state_q == StBusy) && !flush_i;
  assign is_div   = op_i[2];
  assign a_signed = is_div ? ~op_i[0] : ~(op_i[1] & op_i[0]);
  assign b_signed = is_div ? ~op_i[0] : ~op_i[1];
  assign sa       = a_signed & op_a_i[DATA_WIDTH-1];
  assign sb       = b_signed & op_b_i[DATA_WIDTH-1];
  assign mag_a    = sa ? -op_a_i : op_a_i;
  assign mag_b    = sb ? -op_b_i : op_b_i;

  // FSM next state, counter and stall
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall_o = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i && !flush_i) begin
          state_d = StBusy;
          cnt_d   = CntW'(DATA_WIDTH - 1);
          stall_o = 1'b1;
        end
      end
      StBusy: begin
        if (flush_i) begin
          state_d = StIdle;
        end else begin
          stall_o = 1'b1;
          if (cnt_q == '0) state_d = StDone;
          else             cnt_d   = cnt_q - 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // One iteration of shift-add or restoring divide
  logic [DATA_WIDTH:0] sum, rem_sh, diff;
  always_comb begin
    sum    = {1'b0, hi_q} + (lo_q[0] ? {1'b0, den_q} : '0);
    rem_sh = {hi_q, lo_q[DATA_WIDTH-1]};
    diff   = rem_sh - {1'b0, den_q};
    hi_d   = hi_q;
    lo_d   = lo_q;
    if (op_q[2]) begin
      if (rem_sh >= {1'b0, den_q}) begin
        hi_d = diff[DATA_WIDTH-1:0];
        lo_d = {lo_q[DATA_WIDTH-2:0], 1'b1};
      end else begin
        hi_d = rem_sh[DATA_WIDTH-1:0];
        lo_d = {lo_q[DATA_WIDTH-2:0], 1'b0};
      end
    end else begin
      hi_d = sum[DATA_WIDTH:1];
      lo_d = {sum[0], lo_q[DATA_WIDTH-1:1]};
    end
  end

  // State, counter and datapath registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      op_q       <= MdMul;
      hi_q       <= '0;
      lo_q       <= '0;
      den_q      <= '0;
      dividend_q <= '0;
      neg_q      <= 1'b0;
      neg_rem_q  <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (load) begin
        op_q       <= muldiv_op_e'(op_i);
        hi_q       <= '0;
        lo_q       <= is_div ? mag_a : mag_b;
        den_q      <= is_div ? mag_b : mag_a;
        dividend_q <= op_a_i;
        neg_q      <= sa ^ sb;
        neg_rem_q  <= sa;
        zero_q     <= (op_b_i == '0);
      end else if (step) begin
        hi_q <= hi_d;
        lo_q <= lo_d;
      end
    end
  end

  // Sign fix-up and result select, presented only in DONE
  logic [2*DATA_WIDTH-1:0] prod, prod_fix;
  logic [DATA_WIDTH-1:0]   quo_fix, rem_fix, res;
  always_comb begin
    prod     = {hi_q, lo_q};
    prod_fix = neg_q ? -prod : prod;
    quo_fix  = neg_q ? -lo_q : lo_q;
    rem_fix  = neg_rem_q ? -hi_q : hi_q;
    unique case (op_q)
      MdMul:                     res = prod_fix[DATA_WIDTH-1:0];
      MdMulh, MdMulhsu, MdMulhu: res = prod_fix[2*DATA_WIDTH-1:DATA_WIDTH];
      MdDiv, MdDivu:             res = zero_q ? '1 : quo_fix;
      default:                   res = zero_q ? dividend_q : rem_fix;
    endcase
    result_o = (state_q == StDone) ? res : '0;
  end

endmodule
`endif

// File: rtl/execute_stage.sv
// Execute stage: forwarding, ALU, branch resolution and the E->M pipeline register.
// EXECUTE_MULDIV_EN builds the iterative muldiv_unit; otherwise MulDivE writes 0 and never stalls.
module execute_stage
  import execute_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned SHAMT_W    = $clog2(DATA_WIDTH)
) (
  input logic            clk,
  input logic            rst,
  execute_stage_if.slave bus
);
  logic [DATA_WIDTH-1:0] fwd_a, fwd_b, src_b, alu_result, ex_result, jalr_sum;
  logic [SHAMT_W-1:0]    shamt;
  logic                  taken;
  logic [DATA_WIDTH-1:0] md_result;
  logic                  md_stall;

  // Operand forwarding; select 11 falls back to the register file value
  always_comb begin
    case (fwd_sel_e'(bus.ForwardAE))
      FwdWb:   fwd_a = bus.ResultW;
      FwdMem:  fwd_a = bus.ALUResultFwdM;
      default: fwd_a = bus.RD1E;
    endcase
    case (fwd_sel_e'(bus.ForwardBE))
      FwdWb:   fwd_b = bus.ResultW;
      FwdMem:  fwd_b = bus.ALUResultFwdM;
      default: fwd_b = bus.RD2E;
    endcase
  end

  assign src_b = bus.ALUSrcE ? bus.ImmExtE : fwd_b;
  assign shamt = src_b[SHAMT_W-1:0];

  // ALU
  always_comb begin
    case (alu_op_e'(bus.ALUControlE))
      AluAdd:   alu_result = fwd_a + src_b;
      AluSub:   alu_result = fwd_a - src_b;
      AluAnd:   alu_result = fwd_a & src_b;
      AluOr:    alu_result = fwd_a | src_b;
      AluXor:   alu_result = fwd_a ^ src_b;
      AluSlt:   alu_result = {{(DATA_WIDTH-1){1'b0}}, ($signed(fwd_a) < $signed(src_b))};
      AluSltu:  alu_result = {{(DATA_WIDTH-1){1'b0}}, (fwd_a < src_b)};
      AluSll:   alu_result = fwd_a << shamt;
      AluSrl:   alu_result = fwd_a >> shamt;
      AluSra:   alu_result = $unsigned($signed(fwd_a) >>> shamt);
      AluPassB: alu_result = src_b;
      default:  alu_result = '0;
    endcase
  end

  // Branch condition on forwarded operands (ignores ALUSrcE)
  always_comb begin
    case (branch_cond_e'(bus.BranchCondE))
      BrEq:    taken = (fwd_a == fwd_b);
      BrNe:    taken = (fwd_a != fwd_b);
      BrLt:    taken = ($signed(fwd_a) < $signed(fwd_b));
      BrGe:    taken = ($signed(fwd_a) >= $signed(fwd_b));
      BrLtu:   taken = (fwd_a < fwd_b);
      BrGeu:   taken = (fwd_a >= fwd_b);
      default: taken = 1'b0;
    endcase
  end

  assign jalr_sum      = fwd_a + bus.ImmExtE;
  assign bus.PCTargetE = bus.JalrE ? {jalr_sum[DATA_WIDTH-1:1], 1'b0} : bus.PCE + bus.ImmExtE;
  assign bus.PCSrcE    = !bus.FlushE && (bus.JumpE || (bus.BranchE && taken));

`ifdef EXECUTE_MULDIV_EN
  muldiv_unit #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_muldiv (
    .clk_i   (clk),
    .rst_i   (rst),
    .start_i (bus.MulDivE),
    .flush_i (bus.FlushE),
    .op_i    (bus.MulDivOpE),
    .op_a_i  (fwd_a),
    .op_b_i  (fwd_b),
    .stall_o (md_stall),
    .result_o(md_result)
  );
`else
  logic unused_muldiv_op;
  assign unused_muldiv_op = ^bus.MulDivOpE;
  assign md_stall         = 1'b0;
  assign md_result        = '0;
`endif

  assign bus.StallE = md_stall;
  assign ex_result  = bus.MulDivE ? md_result : alu_result;

  // E->M register; a flushed or stalled E inserts a bubble
  always_ff @(posedge clk) begin
    if (rst || bus.FlushE || md_stall) begin
      bus.RegWriteM   <= 1'b0;
      bus.MemWriteM   <= 1'b0;
      bus.ResultsSrcM <= '0;
      bus.ALUResultM  <= '0;
      bus.WriteDataM  <= '0;
      bus.PCPlus4M    <= '0;
      bus.RdM         <= '0;
    end else begin
      bus.RegWriteM   <= bus.RegWriteE;
      bus.MemWriteM   <= bus.MemWriteE;
      bus.ResultsSrcM <= bus.ResultsSrcE;
      bus.ALUResultM  <= ex_result;
      bus.WriteDataM  <= fwd_b;
      bus.PCPlus4M    <= bus.PCPlus4E;
      bus.RdM         <= bus.RdE;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage; muldiv sequences follow EXECUTE_MULDIV_EN.
module tb_execute_stage;
  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   stalls;
  int   bubbles;

  execute_stage_if #(.DATA_WIDTH(32)) bus ();

  execute_stage #(
    .DATA_WIDTH(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.FlushE = 0; bus.RegWriteE = 0; bus.MemWriteE = 0; bus.JumpE = 0; bus.BranchE = 0;
    bus.JalrE = 0; bus.ALUSrcE = 0; bus.MulDivE = 0; bus.ResultsSrcE = 0; bus.ALUControlE = 0;
    bus.BranchCondE = 0; bus.MulDivOpE = 0; bus.ForwardAE = 0; bus.ForwardBE = 0;
    bus.RD1E = 0; bus.RD2E = 0; bus.PCE = 0; bus.ImmExtE = 0; bus.PCPlus4E = 0;
    bus.ResultW = 0; bus.ALUResultFwdM = 0; bus.RdE = 0;
  endtask

  task automatic alu_case(input string tag, input logic [3:0] ctl, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
    bus.ALUControlE = ctl; bus.RD1E = a; bus.RD2E = b;
    bus.ForwardAE = 0; bus.ForwardBE = 0; bus.ALUSrcE = 0;
    tick();
    chk(tag, bus.ALUResultM, exp);
  endtask

  task automatic check_m_zero(input string tag);
    chk({tag, "_regwrite"}, {31'b0, bus.RegWriteM}, 0);
    chk({tag, "_memwrite"}, {31'b0, bus.MemWriteM}, 0);
    chk({tag, "_rsrc"}, {30'b0, bus.ResultsSrcM}, 0);
    chk({tag, "_alures"}, bus.ALUResultM, 0);
    chk({tag, "_wdata"}, bus.WriteDataM, 0);
    chk({tag, "_pc4"}, bus.PCPlus4M, 0);
    chk({tag, "_rd"}, {27'b0, bus.RdM}, 0);
  endtask

`ifdef EXECUTE_MULDIV_EN
  task automatic run_md(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    clear_inputs();
    bus.MulDivE = 1; bus.MulDivOpE = op; bus.RD1E = a; bus.RD2E = b;
    bus.RegWriteE = 1; bus.RdE = 5'd7;
    #1;
    stalls = 0;
    bubbles = 0;
    for (int i = 0; i < 100 && bus.StallE === 1'b1; i++) begin
      stalls++;
      tick();
      if (bus.RegWriteM === 1'b0 && bus.ALUResultM === 32'd0 && bus.RdM === 5'd0) bubbles++;
    end
    chk({tag, "_stalls"}, stalls, 33);
    chk({tag, "_bubbles"}, bubbles, 33);
    tick();
    chk({tag, "_result"}, bus.ALUResultM, exp);
    chk({tag, "_rd"}, {27'b0, bus.RdM}, 7);
    clear_inputs();
  endtask
`endif

  initial begin
    checks = 0;
    failures = 0;
    clear_inputs();
    rst = 1;
    tick();
    tick();
    check_m_zero("reset");
    chk("reset_stall", {31'b0, bus.StallE}, 0);
    rst = 0;

    // ADD with A forwarded from M
    bus.ALUControlE = 4'd0; bus.ForwardAE = 2'b10; bus.ALUResultFwdM = 5; bus.RD2E = 7;
    bus.RegWriteE = 1; bus.RdE = 5'd3; bus.PCPlus4E = 32'h104;
    tick();
    chk("add_fwdm", bus.ALUResultM, 12);
    chk("add_wdata", bus.WriteDataM, 7);
    chk("add_rd", {27'b0, bus.RdM}, 3);
    chk("add_regwrite", {31'b0, bus.RegWriteM}, 1);
    chk("add_pc4", bus.PCPlus4M, 32'h104);

    // SUB with A from W and B from M
    bus.ALUControlE = 4'd1; bus.ForwardAE = 2'b01; bus.ResultW = 100;
    bus.ForwardBE = 2'b10; bus.ALUResultFwdM = 58;
    tick();
    chk("sub_fwd", bus.ALUResultM, 42);
    chk("sub_wdata", bus.WriteDataM, 58);

    // Select 11 behaves like 00
    bus.ALUControlE = 4'd0; bus.ForwardAE = 2'b11; bus.ForwardBE = 2'b11;
    bus.RD1E = 9; bus.RD2E = 4;
    tick();
    chk("fwd11", bus.ALUResultM, 13);

    // Immediate operand, WriteData stays forwarded B
    bus.ForwardAE = 0; bus.ForwardBE = 0; bus.ALUSrcE = 1; bus.ImmExtE = 4;
    bus.RD1E = 32'h8000_0000; bus.RD2E = 32'h55; bus.ALUControlE = 4'd9;
    tick();
    chk("sra_imm", bus.ALUResultM, 32'hF800_0000);
    chk("sra_wdata", bus.WriteDataM, 32'h55);
    bus.ALUControlE = 4'd8;
    tick();
    chk("srl_imm", bus.ALUResultM, 32'h0800_0000);
    bus.ALUControlE = 4'd10; bus.ImmExtE = 32'h1234;
    tick();
    chk("passb", bus.ALUResultM, 32'h1234);

    alu_case("slt", 4'd5, 32'hFFFF_FFFF, 1, 1);
    alu_case("sltu", 4'd6, 32'hFFFF_FFFF, 1, 0);
    alu_case("sll_low_bits", 4'd7, 3, 32'h21, 6);
    alu_case("xor", 4'd4, 32'hF0F0, 32'h0FF0, 32'hFF00);
    alu_case("and", 4'd2, 32'hF0F0, 32'h0FF0, 32'h00F0);
    alu_case("or", 4'd3, 32'hF0F0, 32'h0FF0, 32'hFFF0);
    alu_case("op12_zero", 4'd12, 5, 3, 0);

    // Branch resolution (combinational)
    clear_inputs();
    bus.BranchE = 1; bus.BranchCondE = 3'b100; bus.RD1E = 32'hFFFF_FFFF; bus.RD2E = 1;
    bus.PCE = 32'h100; bus.ImmExtE = 32'h20;
    #1;
    chk("blt_taken", {31'b0, bus.PCSrcE}, 1);
    chk("blt_target", bus.PCTargetE, 32'h120);
    bus.BranchCondE = 3'b110;
    #1;
    chk("bltu_not_taken", {31'b0, bus.PCSrcE}, 0);
    bus.BranchCondE = 3'b010; bus.RD2E = 32'hFFFF_FFFF;
    #1;
    chk("cond010_never", {31'b0, bus.PCSrcE}, 0);
    bus.BranchCondE = 3'b000;
    #1;
    chk("beq_taken", {31'b0, bus.PCSrcE}, 1);
    clear_inputs();
    bus.JumpE = 1; bus.JalrE = 1; bus.RD1E = 32'h201; bus.ImmExtE = 32'h10; bus.PCE = 32'h400;
    #1;
    chk("jalr_target", bus.PCTargetE, 32'h210);
    chk("jalr_redirect", {31'b0, bus.PCSrcE}, 1);
    bus.FlushE = 1; bus.RegWriteE = 1; bus.MemWriteE = 1; bus.RdE = 5'd4; bus.PCPlus4E = 32'h8;
    #1;
    chk("flush_no_redirect", {31'b0, bus.PCSrcE}, 0);
    tick();
    chk("flush_bubble_rw", {31'b0, bus.RegWriteM}, 0);
    chk("flush_bubble_rd", {27'b0, bus.RdM}, 0);
    chk("flush_bubble_pc4", bus.PCPlus4M, 0);

    // Reset clears a populated M register
    clear_inputs();
    bus.RegWriteE = 1; bus.MemWriteE = 1; bus.ResultsSrcE = 2'd2; bus.RD1E = 11; bus.RD2E = 22;
    bus.RdE = 5'd9; bus.PCPlus4E = 32'h44;
    tick();
    chk("pre_reset_alu", bus.ALUResultM, 33);
    chk("pre_reset_rsrc", {30'b0, bus.ResultsSrcM}, 2);
    rst = 1;
    tick();
    rst = 0;
    check_m_zero("reset_mid");
    clear_inputs();

`ifdef EXECUTE_MULDIV_EN
    run_md("mul", 3'b000, 6, 7, 42);
    run_md("div_by_zero", 3'b100, 7, 0, 32'hFFFF_FFFF);
    run_md("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_md("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run_md("div_neg", 3'b100, 32'hFFFF_FFF9, 2, 32'hFFFF_FFFD);
    run_md("rem_neg", 3'b110, 32'hFFFF_FFF9, 2, 32'hFFFF_FFFF);
    run_md("divu", 3'b101, 100, 7, 14);
    run_md("remu", 3'b111, 100, 7, 2);
    run_md("mulhu", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_md("mulh", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_md("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    // Flush on the 10th BUSY cycle of DIVU
    bus.MulDivE = 1; bus.MulDivOpE = 3'b101; bus.RD1E = 100; bus.RD2E = 7; bus.RegWriteE = 1;
    bus.RdE = 5'd6;
    for (int i = 0; i < 10; i++) tick();
    chk("divu_busy_stall", {31'b0, bus.StallE}, 1);
    bus.FlushE = 1;
    #1;
    chk("divu_flush_stall", {31'b0, bus.StallE}, 0);
    tick();
    chk("divu_flush_bubble_rw", {31'b0, bus.RegWriteM}, 0);
    chk("divu_flush_bubble_res", bus.ALUResultM, 0);
    clear_inputs();
    bus.RD1E = 2; bus.RD2E = 3; bus.RegWriteE = 1; bus.RdE = 5'd9;
    #1;
    chk("post_flush_stall", {31'b0, bus.StallE}, 0);
    tick();
    chk("post_flush_add", bus.ALUResultM, 5);
    chk("post_flush_rd", {27'b0, bus.RdM}, 9);

    // Reset during BUSY
    clear_inputs();
    bus.MulDivE = 1; bus.MulDivOpE = 3'b000; bus.RD1E = 6; bus.RD2E = 7;
    for (int i = 0; i < 5; i++) tick();
    rst = 1;
    bus.MulDivE = 0;
    tick();
    rst = 0;
    check_m_zero("rst_busy");
    chk("rst_busy_stall", {31'b0, bus.StallE}, 0);
    tick();
    chk("rst_busy_stall_later", {31'b0, bus.StallE}, 0);
`else
    // Without the muldiv unit MUL passes controls and writes 0 without stalling
    bus.MulDivE = 1; bus.MulDivOpE = 3'b000; bus.RD1E = 6; bus.RD2E = 7;
    bus.RegWriteE = 1; bus.RdE = 5'd5;
    #1;
    chk("nomd_stall", {31'b0, bus.StallE}, 0);
    tick();
    chk("nomd_result", bus.ALUResultM, 0);
    chk("nomd_regwrite", {31'b0, bus.RegWriteM}, 1);
    chk("nomd_rd", {27'b0, bus.RdM}, 5);
    chk("nomd_wdata", bus.WriteDataM, 7);
    chk("nomd_stall_after", {31'b0, bus.StallE}, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/execute_stage.md
EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, default 32, datapath width (≥8, power of 2); SHAMT_W, default $clog2(DATA_WIDTH), shift-amount bits.
REQ-002 Ports SHALL be (name direction width meaning):
 clk  in  1  single clock, rising edge
 rst  in  1  synchronous, active-high reset
 FlushE  in  1  squash instruction in EX
 RegWriteE, MemWriteE, JumpE, BranchE, JalrE, ALUSrcE, MulDivE  in  1 each  decoded controls
 ResultsSrcE  in  2  writeback select
 ALUControlE  in  4  ALU op
 BranchCondE  in  3  funct3 branch condition
 MulDivOpE  in  3  funct3 M-extension op
 ForwardAE, ForwardBE  in  2  operand forwarding select
 RD1E, RD2E, PCE, ImmExtE, PCPlus4E  in  DATA_WIDTH  operands/PC
 ResultW, ALUResultFwdM  in  DATA_WIDTH  forwarded values from W and M
 RdE  in  5  destination register
 RegWriteM, MemWriteM  out  1  registered controls
 ResultsSrcM  out  2
 ALUResultM, WriteDataM, PCPlus4M  out  DATA_WIDTH  registered data
 RdM  out  5
 PCTargetE  out  DATA_WIDTH  combinational branch/jump target
 PCSrcE  out  1  combinational redirect
 StallE  out  1  combinational; hold F/D/E stages

Function
REQ-003 Forward select SHALL be: 00 RD1E/RD2E, 01 ResultW, 10 ALUResultFwdM, 11 treated as 00.
REQ-004 SrcB SHALL be ImmExtE when ALUSrcE=1, else forwarded B; WriteData SHALL always be forwarded B.
REQ-005 ALUControlE SHALL decode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLTU, 7 SLL, 8 SRL, 9 SRA, 10 pass-B; 11–15 yield 0; shifts use SrcB[SHAMT_W-1:0].
REQ-006 BranchCondE SHALL decode on forwarded A/B: 000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU; 010/011 never taken.
REQ-007 PCTargetE SHALL be PCE+ImmExtE, or (fwdA+ImmExtE) with bit0 cleared when JalrE=1; PCSrcE SHALL be JumpE | (BranchE & taken), forced 0 when FlushE=1.
REQ-008 Each edge with FlushE=1, or StallE=1, SHALL load a bubble into the M register: RegWriteM=0, MemWriteM=0, ResultsSrcM=0, RdM=0, data 0.
REQ-009 Otherwise the M register SHALL capture E controls, RdE, PCPlus4E, WriteData, and ALUResultM = muldiv result if MulDivE else ALU result.
REQ-010 Muldiv FSM states SHALL be IDLE, BUSY, DONE; IDLE→BUSY on MulDivE & ~FlushE (operands latched, counter=DATA_WIDTH-1); BUSY→DONE when counter reaches 0; DONE→IDLE unconditionally.
REQ-011 StallE SHALL be 1 in IDLE when MulDivE & ~FlushE, and throughout BUSY; 0 in DONE; total stall DATA_WIDTH+1 cycles.
REQ-012 MulDivOpE SHALL decode: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU; one result bit per BUSY cycle (shift-add / restoring), signed via magnitude plus sign fix-up.
REQ-013 Divide by zero SHALL give quotient all-ones and remainder = dividend; signed overflow (MIN / -1) SHALL give quotient MIN, remainder 0.
REQ-014 FlushE in BUSY or DONE SHALL abort to IDLE next edge, deassert StallE immediately, and discard the result; flush has priority over stall.

Reset
REQ-015 rst SHALL, at the clock edge, clear every M-register output to 0, set FSM to IDLE and counter to 0.
REQ-016 rst mid-operation SHALL abandon the muldiv without producing a result; StallE SHALL be 0 in the cycle after reset.

Configuration
REQ-017 With EXECUTE_MULDIV_EN defined, the muldiv unit and FSM SHALL be built per REQ-010..014.
REQ-018 Without EXECUTE_MULDIV_EN, StallE SHALL be tied 0, no FSM exists, and MulDivE instructions SHALL write ALUResultM=0 with the other controls passed through.

Structure
REQ-019 Package execute_pkg SHALL hold alu_op_e, branch_cond_e, muldiv_op_e, fwd_sel_e, and muldiv_state_e enums.
REQ-020 The iterative multiply/divide datapath and FSM SHALL be the sub-module muldiv_unit; ALU, forwarding, and the M register stay in execute_stage.

Verification
REQ-021 ADD with ForwardAE=10, ALUResultFwdM=5, RD2E=7 -> ALUResultM=12 next edge.
REQ-022 BLT, A=-1, B=1, PCE=0x100, Imm=0x20 -> PCSrcE=1, PCTargetE=0x120; BLTU same operands -> PCSrcE=0.
REQ-023 MUL 6×7 (DATA_WIDTH=32) -> StallE high 33 cycles, 33 bubbles at M, then ALUResultM=42.
REQ-024 DIV 7/0 -> ALUResultM=0xFFFFFFFF; REM 0x80000000 % -1 -> 0; DIV 0x80000000 / -1 -> 0x80000000.
REQ-025 FlushE on the 10th BUSY cycle of DIVU -> StallE=0 that cycle, bubble at M, FSM IDLE; the next ADD completes normally.
REQ-026 rst asserted during BUSY -> all M outputs 0, StallE=0 after the edge; rebuild without EXECUTE_MULDIV_EN -> MUL never stalls and gives ALUResultM=0.
